// File: rtl/vector_pkg.sv
// Shared definitions for the vector MEM-stage sequencer.
//   LANES / DATA_W / ADDR_W : default vector geometry
//   vec_mem_state_t         : sequencer FSM states
//   lane_idx_t              : lane index, $clog2(LANES) bits (minimum 1)
package vector_pkg;

    localparam int unsigned LANES  = 4;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 32;

    localparam int unsigned LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

    typedef logic [LANE_W-1:0] lane_idx_t;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DRAIN,
        DONE
    } vec_mem_state_t;

endpackage

// File: rtl/vector_mem_sequencer.sv
// Serialises a LANES-wide vector load/store into one element per cycle on a
// single-port synchronous data memory, gathering load data back into a vector.
//   clk, rst       : clock, synchronous active-high reset
//   start          : request, sampled only in IDLE (with is_store)
//   is_store       : 1 = vector store, 0 = vector load
//   addressVector  : LANES element addresses, passed through unmodified
//   storeVector    : LANES store data elements
//   mem_addr/wdata : memory address / write data for the current element
//   mem_we/mem_re  : memory write / read enable (never both high)
//   mem_rdata      : read data, valid the cycle after mem_re
//   loadVector     : gathered load result, changes only on element capture
//   stall          : high in ACCESS and DRAIN
//   done           : one-cycle completion pulse
module vector_mem_sequencer
    import vector_pkg::*;
#(
    parameter int unsigned LANES  = vector_pkg::LANES,
    parameter int unsigned DATA_W = vector_pkg::DATA_W,
    parameter int unsigned ADDR_W = vector_pkg::ADDR_W
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          is_store,
    input  logic [LANES-1:0][ADDR_W-1:0]  addressVector,
    input  logic [LANES-1:0][DATA_W-1:0]  storeVector,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic [DATA_W-1:0]             mem_wdata,
    output logic                          mem_we,
    output logic                          mem_re,
    input  logic [DATA_W-1:0]             mem_rdata,
    output logic [LANES-1:0][DATA_W-1:0]  loadVector,
    output logic                          stall,
    output logic                          done
);

    localparam int unsigned LW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [LW-1:0] LAST_LANE = LW'(LANES - 1);

    vec_mem_state_t                 state_q, state_d;
    logic [LW-1:0]                  lane_q, lane_d;
    logic [LANES-1:0][ADDR_W-1:0]   addr_q;
    logic [LANES-1:0][DATA_W-1:0]   data_q;
    logic                           is_store_q;
    logic [LANES-1:0][DATA_W-1:0]   load_q;

    // Read data lags the issued lane by one cycle: remember which lane is
    // in flight so its data lands in the right slot on the next edge.
    logic                           cap_vld_q;
    logic [LW-1:0]                  cap_idx_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            lane_q     <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            is_store_q <= 1'b0;
            load_q     <= '0;
            cap_vld_q  <= 1'b0;
            cap_idx_q  <= '0;
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            if (state_q == IDLE && start) begin
                addr_q     <= addressVector;
                data_q     <= storeVector;
                is_store_q <= is_store;
            end
            cap_vld_q <= (state_q == ACCESS) && !is_store_q;
            cap_idx_q <= lane_q;
            if (cap_vld_q) begin
                load_q[cap_idx_q] <= mem_rdata;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        lane_d    = lane_q;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        stall     = 1'b0;
        done      = 1'b0;
        case (state_q)
            IDLE: begin
                lane_d = '0;
                if (start) begin
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                stall     = 1'b1;
                mem_addr  = addr_q[lane_q];
                mem_wdata = data_q[lane_q];
                mem_we    = is_store_q;
                mem_re    = !is_store_q;
                if (lane_q == LAST_LANE) begin
                    lane_d  = '0;
                    state_d = is_store_q ? DONE : DRAIN;
                end else begin
                    lane_d = lane_q + LW'(1);
                end
            end
            DRAIN: begin
                stall   = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign loadVector = load_q;

endmodule

// File: tb/tb_vector_mem_sequencer.sv
// Randomised and directed bench for vector_mem_sequencer with a behavioural
// memory and a reference model of the vector load/store semantics.
module tb_vector_mem_sequencer;
    import vector_pkg::*;

    localparam int unsigned L  = LANES;
    localparam int unsigned CW = 256;

    logic                       clk = 1'b0;
    logic                       rst;
    logic                       start;
    logic                       is_store;
    logic [L-1:0][ADDR_W-1:0]   addressVector;
    logic [L-1:0][DATA_W-1:0]   storeVector;
    logic [ADDR_W-1:0]          mem_addr;
    logic [DATA_W-1:0]          mem_wdata;
    logic                       mem_we;
    logic                       mem_re;
    logic [DATA_W-1:0]          mem_rdata = '0;
    logic [L-1:0][DATA_W-1:0]   loadVector;
    logic                       stall;
    logic                       done;

    int unsigned checks = 0;
    int unsigned errors = 0;

    // Memory written by the DUT, and the reference memory written by the model.
    logic [DATA_W-1:0] mem     [logic [ADDR_W-1:0]];
    logic [DATA_W-1:0] ref_mem [logic [ADDR_W-1:0]];
    logic [L-1:0][DATA_W-1:0] exp_lv;

    always #5 clk = ~clk;

    vector_mem_sequencer #(
        .LANES  (L),
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .is_store      (is_store),
        .addressVector (addressVector),
        .storeVector   (storeVector),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_we        (mem_we),
        .mem_re        (mem_re),
        .mem_rdata     (mem_rdata),
        .loadVector    (loadVector),
        .stall         (stall),
        .done          (done)
    );

    function automatic logic [DATA_W-1:0] fill(input logic [ADDR_W-1:0] a);
        return DATA_W'(a) ^ DATA_W'(32'h5A5A_0F0F);
    endfunction

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] = mem_wdata;
        if (mem_re) mem_rdata <= mem.exists(mem_addr) ? mem[mem_addr] : fill(mem_addr);
    end

    task automatic check(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst === 1'b0) check("we_re_excl", CW'(mem_we & mem_re), '0);
    end

    function automatic logic [L-1:0][ADDR_W-1:0] seq_addr(input logic [ADDR_W-1:0] base);
        logic [L-1:0][ADDR_W-1:0] a;
        for (int i = 0; i < L; i++) a[i] = base + ADDR_W'(i);
        return a;
    endfunction

    function automatic logic [L-1:0][DATA_W-1:0] rand_data();
        logic [L-1:0][DATA_W-1:0] d;
        for (int i = 0; i < L; i++) d[i] = DATA_W'($urandom);
        return d;
    endfunction

    task automatic scramble_inputs();
        addressVector = seq_addr(ADDR_W'($urandom));
        storeVector   = rand_data();
        is_store      = 1'($urandom);
    endtask

    // Called in an IDLE cycle away from the clock edge; returns one cycle
    // after done, again in IDLE, so operations can run back to back.
    task automatic run_op(input logic st, input logic [L-1:0][ADDR_W-1:0] a,
                          input logic [L-1:0][DATA_W-1:0] d, input bit poke);
        int unsigned lat;
        logic [L-1:0][DATA_W-1:0] nv;
        lat = st ? L + 1 : L + 2;
        nv  = exp_lv;
        for (int i = 0; i < L; i++) begin
            if (st) ref_mem[a[i]] = d[i];
            else    nv[i] = ref_mem.exists(a[i]) ? ref_mem[a[i]] : fill(a[i]);
        end
        is_store      = st;
        addressVector = a;
        storeVector   = d;
        start         = 1'b1;
        for (int k = 1; k <= int'(lat); k++) begin
            @(posedge clk); #1;
            start = 1'b0;
            scramble_inputs();
            if (poke && k == 2) begin
                start = 1'b1;
                addressVector = seq_addr(ADDR_W'(100));
            end
            @(negedge clk);
            check("stall", CW'(stall), CW'(k <= int'(lat) - 1));
            check("done", CW'(done), CW'(k == int'(lat)));
            if (k <= int'(L)) begin
                check("we", CW'(mem_we), CW'(st));
                check("re", CW'(mem_re), CW'(!st));
                check("addr", CW'(mem_addr), CW'(a[k-1]));
                if (st) check("wdata", CW'(mem_wdata), CW'(d[k-1]));
            end else begin
                check("we_idle", CW'(mem_we), '0);
                check("re_idle", CW'(mem_re), '0);
            end
            if (st) check("lv_hold", CW'(loadVector), CW'(exp_lv));
        end
        if (poke) begin
            start = 1'b1;
            addressVector = seq_addr(ADDR_W'(100));
            is_store = 1'b1;
        end
        @(posedge clk); #1;
        start  = 1'b0;
        exp_lv = nv;
        check("post_done", CW'(done), '0);
        check("post_stall", CW'(stall), '0);
        check("post_we_re", CW'({mem_we, mem_re}), '0);
        check("loadVector", CW'(loadVector), CW'(exp_lv));
    endtask

    task automatic reset_mid_load(input logic [L-1:0][ADDR_W-1:0] a);
        is_store      = 1'b0;
        addressVector = a;
        storeVector   = '0;
        start         = 1'b1;
        for (int k = 1; k <= 2; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
            scramble_inputs();
            @(negedge clk);
            check("rml_re", CW'(mem_re), 1);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_lv = '0;
        check("rml_we_re", CW'({mem_we, mem_re}), '0);
        check("rml_stall", CW'(stall), '0);
        check("rml_done", CW'(done), '0);
        check("rml_lv", CW'(loadVector), '0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("rml_idle", CW'({done, stall, mem_we, mem_re}), '0);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        logic [L-1:0][DATA_W-1:0] d;
        logic [L-1:0][ADDR_W-1:0] a;
        logic [ADDR_W-1:0]        base;

        rst = 1'b1;
        start = 1'b0;
        is_store = 1'b0;
        addressVector = '0;
        storeVector = '0;
        exp_lv = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_mem", CW'({mem_addr, mem_wdata, mem_we, mem_re}), '0);
        check("rst_lv", CW'(loadVector), '0);
        check("rst_ctl", CW'({stall, done}), '0);
        rst = 1'b0;

        d[0] = 32'h5; d[1] = 32'h8; d[2] = 32'h12; d[3] = 32'h20;
        for (int i = 0; i < L; i++) begin
            mem[ADDR_W'(3 + i)]     = d[i];
            ref_mem[ADDR_W'(3 + i)] = d[i];
        end

        run_op(1'b1, seq_addr(ADDR_W'(3)), d, 1'b0);
        run_op(1'b0, seq_addr(ADDR_W'(3)), '0, 1'b0);
        run_op(1'b0, seq_addr(ADDR_W'(3)), '0, 1'b1);
        run_op(1'b1, seq_addr(ADDR_W'(40)), rand_data(), 1'b1);
        reset_mid_load(seq_addr(ADDR_W'(3)));
        run_op(1'b0, seq_addr(ADDR_W'(3)), '0, 1'b0);
        run_op(1'b1, seq_addr(32'hFFFF_FFFE), rand_data(), 1'b0);
        run_op(1'b0, seq_addr(32'hFFFF_FFFE), '0, 1'b0);

        // back-to-back store then load of the same addresses
        d = rand_data();
        run_op(1'b1, seq_addr(ADDR_W'(20)), d, 1'b0);
        run_op(1'b0, seq_addr(ADDR_W'(20)), '0, 1'b0);
        check("b2b_lv", CW'(loadVector), CW'(d));

        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 4) == 0) base = ADDR_W'($urandom);
            else                           base = ADDR_W'($urandom_range(0, 40));
            a = seq_addr(base);
            run_op(1'($urandom), a, rand_data(), 1'($urandom));
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
